idft_16to32: RTL
================

IDFT_16TO32 -- requirements
Module: idft_16to32

Interface
REQ-001 Parameter IN_W, default 8, signed input sample width.
REQ-002 Parameter OUT_W, default 8, signed output sample width; SHALL be >= IN_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_data  input  IN_W  signed sample; frame order is fa0..fa15, then fb0..fb15.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_data  output  OUT_W  signed reconstructed sample, frame order x0..x31.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_last  output  1  high with out_valid on x31 only.

Function
REQ-012 Transfers SHALL occur only when valid and ready are both high on the same edge; in_ready SHALL NOT depend combinationally on in_valid.
REQ-013 Per n in 0..15, the block SHALL compute x[n] = (fa[n]+fb[n]) >>> 1 and x[n+16] = (fa[n]-fb[n]) >>> 1.
REQ-014 Sum and difference SHALL be formed at IN_W+1 bits, arithmetic-shifted right by 1 (floor), and sign-extended to OUT_W; no saturation is needed.
REQ-015 A 16-entry x IN_W buffer SHALL hold fa[n] during LOAD_A; during MERGE entry n SHALL be overwritten with x[n+16].
REQ-016 States: LOAD_A, MERGE, DRAIN; a 4-bit index counts 0..15 in each state.
REQ-017 LOAD_A: in_ready=1, out_valid=0; each accepted sample is written to buf[idx]; on idx=15 accept -> MERGE, idx=0.
REQ-018 MERGE: in_ready = !out_valid | out_ready; accepted fb[idx] loads the output register with x[idx] the next cycle (latency 1); on idx=15 accept -> DRAIN, idx=0.
REQ-019 DRAIN: in_ready=0; the output register is loaded with buf[idx] whenever it is empty or is being consumed; after x31 is consumed -> LOAD_A, idx=0.
REQ-020 Output register: out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 The MERGE->DRAIN boundary SHALL be seamless: with out_ready held high, x0..x31 appear on 32 consecutive cycles starting one cycle after fb0 is accepted.
REQ-022 in_valid during DRAIN SHALL be ignored; no input is lost because in_ready=0.
REQ-023 The first sample of the next frame SHALL be accepted no earlier than the cycle after x31 is consumed.

Reset
REQ-024 On rst=1 at a clock edge: state=LOAD_A, idx=0, out_valid=0, out_data=0, out_last=0; in_ready=1 the cycle after.
REQ-025 Reset mid-frame in any state SHALL discard the partial frame; buffer contents need not be cleared.

Structure
REQ-026 Package fft_pkg SHALL hold the constants FFT_N=32 and FFT_HALF=16 and the state enum type.
REQ-027 One combinational sub-module, ibut_real (IN_W/OUT_W parameters; inputs a, b; outputs p=(a+b)>>>1 and n=(a-b)>>>1), SHALL perform REQ-013/014.
REQ-028 The buffer SHALL be a register array with one read port and one write port, to allow RAM inference.

Verification (IN_W=OUT_W=8)
REQ-029 Frame: fa=10 x16, fb=4 x16, out_ready=1 -> x0..x15=7, x16..x31=3, out_last only on x31, 32 consecutive valid cycles.
REQ-030 Rounding: fa0=-3, fb0=0 -> x0=-2, x16=-2; fa1=3, fb1=0 -> x1=1, x17=1.
REQ-031 Extremes: (127,127)->x=127, x+16=0; (-128,-128)->-128, 0; (127,-128)->-1, 127.
REQ-032 Backpressure: out_ready low for 3 cycles at x5 and at x20 -> in_ready low during those cycles in MERGE, out_data stable, no sample lost or duplicated.
REQ-033 Reset asserted at x20 in DRAIN -> out_valid=0 next cycle; the following full frame reconstructs correctly.
REQ-034 Random 200 frames with random valid and ready gaps -> output matches the reference model bit-exactly.

Source files
------------

// File: rtl/idft_16to32_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Shared constants and the controller state type for the 32-point real
//   IDFT merge stage (two 16-point half spectra -> 32 time samples).
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N    = 32;
    localparam int FFT_HALF = 16;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_MERGE  = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

endpackage

// File: rtl/idft_16to32_if.sv
// ---------------------------------------------------------------------------
// idft_16to32_if
//   Streaming bus for idft_16to32.
//   in_data/in_valid/in_ready    : input sample stream (fa0..fa15, fb0..fb15)
//   out_data/out_valid/out_ready : output sample stream (x0..x31)
//   out_last                     : marks x31
//   master : stream producer/consumer (testbench or upstream logic)
//   slave  : the idft_16to32 block
// ---------------------------------------------------------------------------
interface idft_16to32_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8
);

    logic signed [IN_W-1:0]  in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

endinterface

// File: rtl/idft_16to32_ibut_real.sv
// ---------------------------------------------------------------------------
// ibut_real
//   Real-valued half-scaled butterfly.
//   a, b : signed IN_W inputs
//   p    : (a + b) >>> 1, sign-extended to OUT_W
//   n    : (a - b) >>> 1, sign-extended to OUT_W
//   The sum/difference is formed one bit wider than the inputs, so after the
//   floor shift the result always fits back into IN_W bits.
// ---------------------------------------------------------------------------
module ibut_real #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [OUT_W-1:0] p,
    output logic signed [OUT_W-1:0] n
);

    logic signed [IN_W:0] sum_s;
    logic signed [IN_W:0] dif_s;

    assign sum_s = (IN_W+1)'(a) + (IN_W+1)'(b);
    assign dif_s = (IN_W+1)'(a) - (IN_W+1)'(b);

    // Arithmetic shift gives floor division; the cast drops the redundant
    // sign bit or sign-extends, depending on OUT_W.
    assign p = OUT_W'(sum_s >>> 1);
    assign n = OUT_W'(dif_s >>> 1);

endmodule

// File: rtl/idft_16to32.sv
// ---------------------------------------------------------------------------
// idft_16to32
//   Merges two 16-sample half spectra fa/fb into 32 time samples:
//     x[n]    = (fa[n] + fb[n]) >>> 1
//     x[n+16] = (fa[n] - fb[n]) >>> 1
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous, active-high reset
//     bus : idft_16to32_if.slave (in_* input stream, out_* output stream)
//   Flow: LOAD_A stores fa into the buffer; MERGE streams x0..x15 out while
//   overwriting each buffer entry with x[n+16]; DRAIN streams x16..x31.
// ---------------------------------------------------------------------------
module idft_16to32
    import fft_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    idft_16to32_if.slave     bus
);

    state_e                  state_r;
    logic [3:0]              idx_r;
    logic signed [IN_W-1:0]  buf_r [FFT_HALF];
    logic signed [OUT_W-1:0] out_data_r;
    logic                    out_valid_r;
    logic                    out_last_r;

    logic                    in_ready_s;
    logic                    in_fire_s;
    logic                    out_fire_s;
    logic                    out_free_s;
    logic                    wr_en_s;
    logic signed [IN_W-1:0]  wr_data_s;
    logic signed [IN_W-1:0]  rd_data_s;
    logic signed [OUT_W-1:0] sum_s;
    logic signed [OUT_W-1:0] dif_s;

    // Output register can take a new value when empty or being consumed.
    assign out_free_s = !out_valid_r || bus.out_ready;
    assign in_fire_s  = bus.in_valid && in_ready_s;
    assign out_fire_s = out_valid_r && bus.out_ready;

    // Single read port: fa[idx] during MERGE, x[idx+16] during DRAIN.
    assign rd_data_s = buf_r[idx_r];

    ibut_real #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_but (
        .a (rd_data_s),
        .b (bus.in_data),
        .p (sum_s),
        .n (dif_s)
    );

    // Input acceptance per state; never looks at in_valid.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_LOAD_A: in_ready_s = 1'b1;
            ST_MERGE:  in_ready_s = out_free_s;
            ST_DRAIN:  in_ready_s = 1'b0;
            default:   in_ready_s = 1'b0;
        endcase
    end

    // Buffer write port: raw fa in LOAD_A, difference term in MERGE.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_data_s = bus.in_data;
        if (in_fire_s) begin
            wr_en_s = 1'b1;
            if (state_r == ST_MERGE) begin
                wr_data_s = dif_s[IN_W-1:0];
            end else begin
                wr_data_s = bus.in_data;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Sample buffer; left unreset so it can map onto a RAM.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_r[idx_r] <= wr_data_s;
        end
    end

    // Frame controller and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_LOAD_A;
            idx_r       <= 4'd0;
            out_data_r  <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD_A: begin
                    if (in_fire_s) begin
                        idx_r <= idx_r + 4'd1;
                        if (idx_r == 4'd15) begin
                            state_r <= ST_MERGE;
                        end
                    end
                end
                ST_MERGE: begin
                    if (in_fire_s) begin
                        out_data_r  <= sum_s;
                        out_valid_r <= 1'b1;
                        out_last_r  <= 1'b0;
                        idx_r       <= idx_r + 4'd1;
                        if (idx_r == 4'd15) begin
                            state_r <= ST_DRAIN;
                        end
                    end else if (out_fire_s) begin
                        out_valid_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Once x31 sits in the output register, only wait for it
                    // to be taken; otherwise keep refilling from the buffer.
                    if (out_last_r) begin
                        if (out_fire_s) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            idx_r       <= 4'd0;
                            state_r     <= ST_LOAD_A;
                        end
                    end else if (out_free_s) begin
                        out_data_r  <= OUT_W'(rd_data_s);
                        out_valid_r <= 1'b1;
                        out_last_r  <= (idx_r == 4'd15);
                        idx_r       <= idx_r + 4'd1;
                    end
                end
                default: begin
                    state_r     <= ST_LOAD_A;
                    idx_r       <= 4'd0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;

endmodule
